regbank_writeback: RTL
======================

// Module: regbank_writeback
// PURPOSE
//  Write-back stage directly upstream of RegBank. Accepts ALU/memory results (data + dest reg)
//  on a valid/ready handshake and buffers them in a small FIFO. Drains one entry per cycle onto
//  ALUBus and a one-hot regEnable into RegBank. Exports a per-register busy scoreboard so decode
//  can stall on pending writes.
// PARAMETERS
//  DATA_W   16  result/ALUBus width
//  NREG     16  registers in RegBank; width of regEnable and busy
//  ADDR_W    4  dest-register index width, clog2(NREG)
//  DEPTH     2  FIFO entries; power of two, >=2
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             asynchronous, active-high reset
//  in_valid   in   1             result offered
//  in_ready   out  1             stage can accept; = !full
//  in_data    in   DATA_W        result value
//  in_dest    in   ADDR_W        destination register index
//  wb_hold    in   1             1 = freeze draining (no write this cycle)
//  ALUBus     out  DATA_W        write data to RegBank
//  regEnable  out  NREG          one-hot write enable to RegBank; all-zero = no write
//  busy       out  NREG          bit i = a buffered entry targets register i
//  count      out  clog2(DEPTH)+1  entries currently buffered
// BEHAVIOUR
//  - Storage: DEPTH x {data, dest}; wr_ptr/rd_ptr of clog2(DEPTH)+1 bits (extra wrap bit).
//    empty = ptrs equal; full = index equal, wrap bits differ. count = wr_ptr - rd_ptr.
//  - Reset (async, reset=1): ptrs=0, count=0, in_ready=1, regEnable=0, busy=0, ALUBus=0,
//    effective immediately. Entries buffered at reset are discarded, never written.
//  - Push: at posedge when in_valid && in_ready; entry stored at wr_ptr, wr_ptr++.
//    in_ready depends only on full, never on in_valid or wb_hold.
//  - Pop/drive (combinational from head): if !empty && !wb_hold: ALUBus = head.data,
//    regEnable = 1<<head.dest; rd_ptr++ at the next posedge (RegBank captures the same edge).
//    Otherwise regEnable = 0 and ALUBus = 0.
//  - Latency: result pushed at edge N is written into RegBank at edge N+1 when FIFO empty
//    and no hold; FIFO order strictly preserved; one write per cycle max.
//  - Simultaneous push+pop: allowed when not full; count unchanged. When full, in_ready=0
//    even if a pop happens that cycle (no pass-through on full).
//  - wb_hold: outputs zero, rd_ptr frozen; pushes continue until full.
//  - busy[i] = OR over valid entries of (dest==i); multiple entries to the same register allowed.
//    Bit clears the cycle after the last such entry pops.
//  - Two buffered writes to the same register both reach RegBank in order; the last value wins.
//  - Pointer wrap: modulo 2*DEPTH; no special case at wrap.
// CONFIGURATION
//  WB_BYPASS_EN defined: when empty && !wb_hold && in_valid, drive ALUBus=in_data and
//    regEnable=1<<in_dest combinationally. Entry is written at edge N and not pushed.
//    busy stays 0 for it; in_ready stays 1.
//  WB_BYPASS_EN undefined: every accepted result goes through the FIFO (1-cycle latency above).
// TESTING
//  1 reset mid-drain: 2 entries buffered, assert reset -> regEnable=0, count=0, busy=0 same cycle;
//    neither entry appears after release.
//  2 single write: in_data=16'hBEEF, dest=5, empty -> next cycle regEnable=16'h0020,
//    ALUBus=16'hBEEF; r5=16'hBEEF after that edge (bypass build: same cycle).
//  3 fill: wb_hold=1, push dest 3 then 3 -> count=2, in_ready=0, busy=16'h0008; third offer stalls.
//    Release hold -> writes 3 then 3 in order; busy clears after the second pop.
//  4 streaming: in_valid=1 each cycle for 8 results, dest 0..7 -> one regEnable bit per cycle, in order.
//    count never exceeds 1 (0 in bypass build); pointers wrap cleanly.
//  5 push while full with simultaneous pop: full, hold released, in_valid=1 -> offer not
//    accepted that cycle; accepted next cycle; count=2->1->1.

Source files
------------

// File: rtl/regbank_writeback.sv
// Write-back buffer in front of RegBank: small FIFO of {data, dest}, one-hot drain, busy scoreboard.
// Optional same-cycle bypass when empty is enabled by defining WB_BYPASS_EN.
module regbank_writeback #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [ADDR_W-1:0]      in_dest,
    input  logic                   wb_hold,
    output logic [DATA_W-1:0]      ALUBus,
    output logic [NREG-1:0]        regEnable,
    output logic [NREG-1:0]        busy,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              empty, full, push, pop, bypass;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign count  = wr_ptr_q - rd_ptr_q;

`ifdef WB_BYPASS_EN
    // Reset gates the bypass so outputs are zero for the whole reset interval.
    assign bypass = empty && !wb_hold && in_valid && !reset;
`else
    assign bypass = 1'b0;
`endif

    // No pass-through when full: a pop in the same cycle does not open in_ready.
    assign in_ready = !full;
    assign push     = in_valid && !full && !bypass;
    assign pop      = !empty && !wb_hold;

    assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_idx] <= in_data;
            dest_q[wr_idx] <= in_dest;
        end
    end

    always_comb begin
        ALUBus    = '0;
        regEnable = '0;
        if (pop) begin
            ALUBus    = data_q[rd_idx];
            regEnable = ONE_HOT0 << dest_q[rd_idx];
        end else if (bypass) begin
            ALUBus    = in_data;
            regEnable = ONE_HOT0 << in_dest;
        end
    end

    // Walk the live window from the head; slots beyond count hold stale entries.
    always_comb begin
        logic [IDX_W-1:0] slot;
        busy = '0;
        slot = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot = rd_idx + IDX_W'(k);
            if (PTR_W'(k) < count) begin
                busy[dest_q[slot]] = 1'b1;
            end
        end
    end

endmodule
